uart_rx_byte: RTL and testbench
===============================

// Module: uart_rx_byte
// PURPOSE
//  Serial UART receiver (8N1, LSB first) feeding the host-command path: recovers bytes from pin rxd
//  and presents them on a stb/ack byte port that drives the rx input of the 16-deep receive byte fifo
//  ahead of the uart_to_sdram command parser. Detects framing errors and overruns.
// PARAMETERS
//  CLKS_PER_BIT  1154  CLK cycles per bit (133 MHz / 115200 baud); legal range 4..65535
//  WIDTH         8     data bits per frame
// PORTS
//  CLK        in   1      system clock, 133 MHz; single clock domain
//  RST        in   1      reset, synchronous, active-low
//  rxd        in   1      asynchronous serial line, idle high
//  o_data     out  WIDTH  received byte; stable while o_stb=1
//  o_stb      out  1      byte valid; held until accepted
//  o_ack      in   1      consumer ready; transfer when o_stb & o_ack in same cycle
//  frame_err  out  1      1-cycle pulse: stop bit sampled low, byte discarded
//  overrun    out  1      1-cycle pulse: byte completed while o_stb still pending, new byte discarded
//  busy       out  1      1 while FSM not in IDLE
// BEHAVIOUR
//  Reset (RST=0 at CLK edge): state=IDLE, o_data=0, o_stb=0, frame_err=0, overrun=0, busy=0,
//   bit/sample counters=0, synchroniser flops=1 (line idle). Reset mid-frame aborts frame, no output.
//  Input sync: rxd through 2 flops -> rxs; all decisions on rxs (2-cycle pin-to-rxs latency).
//  Sample counter cnt: width $clog2(CLKS_PER_BIT); HALF = CLKS_PER_BIT/2 (integer floor).
//  FSM:
//   IDLE : busy=0; rxs==0 -> START, cnt=0.
//   START: cnt++; at cnt==HALF-1: rxs==0 -> DATA, cnt=0, bit=0; rxs==1 -> IDLE (glitch, no error).
//   DATA : cnt++; at cnt==CLKS_PER_BIT-1: shift rxs into sh[bit] (LSB first), cnt=0;
//          bit==WIDTH-1 -> STOP else bit++.
//   STOP : cnt++; at cnt==CLKS_PER_BIT-1: rxs==1 -> deliver; rxs==0 -> frame_err pulse; -> IDLE.
//          IDLE accepts next start edge immediately (next frame may begin half a bit after stop sample).
//  Deliver: if o_stb==0 or (o_stb & o_ack) this cycle -> o_data<=sh, o_stb<=1 next cycle;
//           else -> overrun pulse, o_data/o_stb unchanged (old byte kept).
//  Handshake: o_stb falls the cycle after o_stb&o_ack unless a new deliver coincides (then stays 1,
//   o_data updates). o_ack while o_stb=0 ignored. o_data must not change while o_stb=1 and unaccepted.
//  Latency: o_stb rises 1 CLK after stop-bit mid-sample (~9.5 bit times after start falling edge + 2 sync).
//  frame_err and overrun never both pulse for one frame; framing-error byte never causes overrun.
//  Break (rxd held low): frame_err once, then FSM waits in IDLE->START loop only after rxs returns high?
//   No: after frame_err FSM enters IDLE; start requires rxs==0 so it re-enters START; to avoid repeated
//   errors IDLE additionally requires rxs to have been 1 for >=1 cycle since last STOP (flag armed).
// STRUCTURE
//  Shared package uart_pkg: state encoding (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3),
//   default CLKS_PER_BIT constant, WIDTH default.
//  One sub-module: rx_sync2 (2-flop synchroniser, reset value 1, same RST). Everything else flat.
// TESTING (bench uses CLKS_PER_BIT=16, WIDTH=8, o_ack=1 unless stated)
//  1 Reset: RST=0 4 cycles, rxd=1 -> all outputs 0, busy=0; release, 100 idle cycles -> no o_stb.
//  2 Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one o_stb with o_data=8'hA5, frame_err=overrun=0.
//  3 Back-to-back 0x00,0xFF,0x3C with no idle gap -> three o_stb pulses, data in order, no errors.
//  4 o_ack=0, send 0x11 then 0x22 -> o_data=0x11 held, overrun pulses once at 0x22 stop; o_ack=1 -> 0x11
//    accepted, o_stb falls, 0x22 never appears.
//  5 Frame 0x55 with stop bit low -> frame_err 1-cycle pulse, no o_stb; hold rxd low 40 bits -> exactly
//    one frame_err; rxd high then 0x66 -> o_data=0x66.
//  6 Low glitch of 5 cycles (< HALF) on idle line -> no output, busy returns 0; RST=0 mid-DATA of 0x77
//    -> no o_stb; next frame 0x12 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver: FSM encoding and default frame geometry.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int CLKS_PER_BIT_DEF = 1154;
  localparam int WIDTH_DEF        = 8;
endpackage

// File: rtl/rx_sync2.sv
// Two-flop synchroniser for the asynchronous serial pin; resets to the idle-high line level.
module rx_sync2 (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);
  logic s1;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end
endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 LSB-first UART receiver with stb/ack byte port, framing-error and overrun pulses.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int WIDTH        = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             rxd,
  output logic [WIDTH-1:0] o_data,
  output logic             o_stb,
  input  logic             o_ack,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic             rxs;
  rx_state_e        state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [BW-1:0]    bit_idx, bit_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic             armed, armed_d;
  logic             deliver, ferr_d;

  rx_sync2 u_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (rxd),
    .q   (rxs)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      armed   <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_d;
      sh      <= sh_d;
      armed   <= armed_d;
    end
  end

  // armed drops at every stop sample so a held-low break line produces a single
  // frame error; the line must go high once before the next start is accepted.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    sh_d    = sh;
    armed_d = armed | rxs;
    deliver = 1'b0;
    ferr_d  = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs && armed) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_d         = '0;
          sh_d[bit_idx] = rxs;
          if (bit_idx == BIT_LAST) state_d = STOP;
          else                     bit_d   = bit_idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_d   = '0;
          state_d = IDLE;
          armed_d = 1'b0;
          if (rxs) deliver = 1'b1;
          else     ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pending unaccepted byte is never overwritten; the new one is dropped instead.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      o_data    <= '0;
      o_stb     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      overrun   <= 1'b0;
      if (deliver) begin
        if (!o_stb || o_ack) begin
          o_data <= sh;
          o_stb  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (o_stb && o_ack) begin
        o_stb <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: table of single frames plus hand-written corner sequences.
module tb_uart_rx_byte;
  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic       rxd;
  logic [7:0] o_data;
  logic       o_stb;
  logic       o_ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] acc_q[$];
  int         ferr_cyc = 0;
  int         ovr_cyc  = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  uart_rx_byte #(.CLKS_PER_BIT(CPB), .WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rxd       (rxd),
    .o_data    (o_data),
    .o_stb     (o_stb),
    .o_ack     (o_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Observe the byte port and error pulses away from the active edge.
  always @(negedge CLK) begin
    if (RST) begin
      if (prev_hold) chk("data_held_while_pending", int'(o_data), int'(prev_data));
      if (o_stb && o_ack) acc_q.push_back(o_data);
      if (frame_err) ferr_cyc++;
      if (overrun)   ovr_cyc++;
      prev_hold = o_stb && !o_ack;
      prev_data = o_data;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_obs();
    acc_q.delete();
    ferr_cyc = 0;
    ovr_cyc  = 0;
  endtask

  // Leaves rxd at the stop level so a low stop can run straight into a break.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxd = 1'b0;
    cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      cyc(CPB);
    end
    rxd = stop;
    cyc(CPB);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_acc;
    logic [7:0] exp_d;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
    vecs[1] = '{8'h5A, 1'b1, 1, 8'h5A, 0};
    vecs[2] = '{8'h80, 1'b1, 1, 8'h80, 0};
    vecs[3] = '{8'h01, 1'b1, 1, 8'h01, 0};
    vecs[4] = '{8'h55, 1'b0, 0, 8'h00, 1};
    vecs[5] = '{8'h66, 1'b1, 1, 8'h66, 0};
    vecs[6] = '{8'hC3, 1'b0, 0, 8'h00, 1};
    vecs[7] = '{8'h12, 1'b1, 1, 8'h12, 0};

    RST   = 1'b0;
    rxd   = 1'b1;
    o_ack = 1'b1;
    @(posedge CLK);
    #1;
    cyc(4);
    chk("reset_o_stb",     int'(o_stb),     0);
    chk("reset_o_data",    int'(o_data),    0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overrun",   int'(overrun),   0);
    chk("reset_busy",      int'(busy),      0);
    RST = 1'b1;
    cyc(100);
    chk("idle_no_bytes", acc_q.size(), 0);
    chk("idle_o_stb",    int'(o_stb),  0);

    foreach (vecs[i]) begin
      clear_obs();
      send_frame(vecs[i].d, vecs[i].stop);
      rxd = 1'b1;
      cyc(40);
      chk($sformatf("vec%0d_count", i), acc_q.size(), vecs[i].exp_acc);
      if (vecs[i].exp_acc > 0 && acc_q.size() > 0)
        chk($sformatf("vec%0d_data", i), int'(acc_q[acc_q.size()-1]), int'(vecs[i].exp_d));
      chk($sformatf("vec%0d_ferr", i), ferr_cyc, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_ovr", i),  ovr_cyc,  0);
      chk($sformatf("vec%0d_busy", i), int'(busy), 0);
    end

    // Back-to-back frames with no idle gap.
    clear_obs();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    rxd = 1'b1;
    cyc(40);
    chk("b2b_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("b2b_byte0", int'(acc_q[0]), 8'h00);
      chk("b2b_byte1", int'(acc_q[1]), 8'hFF);
      chk("b2b_byte2", int'(acc_q[2]), 8'h3C);
    end
    chk("b2b_ferr", ferr_cyc, 0);
    chk("b2b_ovr",  ovr_cyc,  0);

    // Overrun: consumer stalled across two frames.
    clear_obs();
    o_ack = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rxd = 1'b1;
    cyc(20);
    chk("ovr_stb_held", int'(o_stb),  1);
    chk("ovr_data_old", int'(o_data), 8'h11);
    chk("ovr_pulses",   ovr_cyc,      1);
    chk("ovr_no_ferr",  ferr_cyc,     0);
    o_ack = 1'b1;
    cyc(3);
    chk("ovr_stb_fall",  int'(o_stb), 0);
    chk("ovr_acc_count", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("ovr_acc_data", int'(acc_q[0]), 8'h11);
    cyc(200);
    chk("ovr_no_second", acc_q.size(), 1);

    // Bad stop bit followed by a long break, then recovery.
    clear_obs();
    send_frame(8'h55, 1'b0);
    cyc(40 * CPB);
    chk("brk_ferr_once", ferr_cyc,     1);
    chk("brk_no_byte",   acc_q.size(), 0);
    chk("brk_idle",      int'(busy),   0);
    rxd = 1'b1;
    cyc(20);
    send_frame(8'h66, 1'b1);
    rxd = 1'b1;
    cyc(40);
    chk("brk_recover_count", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("brk_recover_data", int'(acc_q[0]), 8'h66);
    chk("brk_ferr_total", ferr_cyc, 1);

    // Short low glitch on an idle line.
    clear_obs();
    rxd = 1'b0;
    cyc(5);
    rxd = 1'b1;
    cyc(4);
    chk("glitch_busy_during", int'(busy), 1);
    cyc(20);
    chk("glitch_busy_after", int'(busy),   0);
    chk("glitch_no_byte",    acc_q.size(), 0);
    chk("glitch_no_ferr",    ferr_cyc,     0);

    // Reset in the middle of a data bit aborts the frame.
    clear_obs();
    rxd = 1'b0;
    cyc(CPB);
    rxd = 1'b1;
    cyc(CPB + 8);
    chk("rst_mid_busy", int'(busy), 1);
    RST = 1'b0;
    cyc(2);
    chk("rst_mid_idle",  int'(busy),  0);
    chk("rst_mid_o_stb", int'(o_stb), 0);
    RST = 1'b1;
    cyc(40);
    chk("rst_mid_no_byte", acc_q.size(), 0);
    send_frame(8'h12, 1'b1);
    rxd = 1'b1;
    cyc(40);
    chk("rst_after_count", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("rst_after_data", int'(acc_q[0]), 8'h12);
    chk("rst_after_ferr", ferr_cyc, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
